// File: rtl/calc_pkg.sv
// Shared definitions for the nexys3 calculator: instruction fields and capture FSM states.
package calc_pkg;

    // Opcode values carried in the top two bits of an instruction word
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    // Instruction word layout: {op[1:0], ra[1:0], rb/immd[3:0]}
    localparam int unsigned INST_W  = 8;
    localparam int unsigned OP_HI   = 7;
    localparam int unsigned OP_LO   = 6;
    localparam int unsigned RA_HI   = 5;
    localparam int unsigned RA_LO   = 4;
    localparam int unsigned RB_HI   = 3;
    localparam int unsigned RB_LO   = 2;
    localparam int unsigned IMMD_HI = 3;
    localparam int unsigned IMMD_LO = 0;

    // Capture FSM states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPend    = 2'd1,
        StWaitRel = 2'd2
    } cap_state_t;

    // Opcode field of an instruction word
    function automatic logic [1:0] inst_op(input logic [INST_W-1:0] wd);
        return wd[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, sample-tick divider and stable-sample counter.
// The debounced level only flips after STABLE_N consecutive differing samples.
module btn_debounce #(
    parameter int unsigned SAMPLE_DIV = 10000,
    parameter int unsigned STABLE_N   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned STB_W = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_N - 1);

    logic             btn_s1;
    logic             btn_s;
    logic [DIV_W-1:0] div_q;
    logic [STB_W-1:0] stb_q;
    logic             tick;

    // Bring the raw button into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s  <= btn_s1;
        end
    end

    assign tick = (div_q == DIV_MAX);

    // Free-running sample divider, wraps after the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Count consecutive samples that disagree with the debounced level; toggle on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q  <= '0;
            btn_db <= 1'b0;
        end else if (tick) begin
            if (btn_s == btn_db) begin
                stb_q <= '0;
            end else if (stb_q == STB_MAX) begin
                btn_db <= ~btn_db;
                stb_q  <= '0;
            end else begin
                stb_q <= stb_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_capture.sv
// Calculator front end: debounces btnS and turns each clean press into exactly one
// valid/ready transfer of the synchronized switch word, counting completed transfers.
module inst_capture #(
    parameter int unsigned SAMPLE_DIV = 10000,
    parameter int unsigned STABLE_N   = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sw,
    input  logic             btnS,
    input  logic             inst_rdy,
    output logic             inst_vld,
    output logic [7:0]       inst_wd,
    output logic             btn_db,
    output logic [CNT_W-1:0] inst_cnt
);

    import calc_pkg::*;

    logic [7:0] sw_s1;
    logic [7:0] sw_s;
    logic       btn_db_d1;
    logic       press_q;
    cap_state_t state_q;

    btn_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .STABLE_N   (STABLE_N)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btnS),
        .btn_db (btn_db)
    );

    // Bring the switch word into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s  <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s  <= sw_s1;
        end
    end

    // One-cycle registered pulse on each rising edge of the debounced button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_d1 <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            btn_db_d1 <= btn_db;
            press_q   <= btn_db & ~btn_db_d1;
        end
    end

    // Capture FSM: latch on press, hold until accepted, then wait for release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            inst_vld <= 1'b0;
            inst_wd  <= '0;
            inst_cnt <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press_q) begin
                        inst_wd  <= sw_s;
                        inst_vld <= 1'b1;
                        state_q  <= StPend;
                    end
                end
                StPend: begin
                    if (inst_rdy) begin
                        inst_vld <= 1'b0;
                        inst_cnt <= inst_cnt + 1'b1;
                        state_q  <= StWaitRel;
                    end
                end
                StWaitRel: begin
                    if (!btn_db) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    inst_vld <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_capture.sv
// Directed bench for inst_capture with a short sample divider (4 clk per tick, 4 stable ticks).
module tb_inst_capture;

    localparam int unsigned SAMPLE_DIV = 4;
    localparam int unsigned STABLE_N   = 4;
    localparam int unsigned CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       sw;
    logic             btnS;
    logic             inst_rdy;
    logic             inst_vld;
    logic [7:0]       inst_wd;
    logic             btn_db;
    logic [CNT_W-1:0] inst_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_capture #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .STABLE_N   (STABLE_N),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btnS     (btnS),
        .inst_rdy (inst_rdy),
        .inst_vld (inst_vld),
        .inst_wd  (inst_wd),
        .btn_db   (btn_db),
        .inst_cnt (inst_cnt)
    );

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles until btn_db equals val; -1 when the bound expires
    task automatic wait_db(input logic val, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (btn_db === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Cycles until inst_vld equals val; -1 when the bound expires
    task automatic wait_vld(input logic val, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (inst_vld === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Full press/accept/release cycle with inst_rdy high
    task automatic press(input logic [7:0] w, input string tag);
        int n;
        sw   = w;
        btnS = 1'b1;
        wait_vld(1'b1, 60, n);
        check({tag, " vld seen"}, 32'(n > 0), 32'd1);
        check({tag, " wd"}, 32'(inst_wd), 32'(w));
        wait_vld(1'b0, 10, n);
        check({tag, " vld drop"}, 32'(n > 0), 32'd1);
        btnS = 1'b0;
        wait_db(1'b0, 60, n);
        check({tag, " release"}, 32'(n > 0), 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        int pulses;
        logic prev;

        // Reset values
        rst = 1'b1; sw = 8'h00; btnS = 1'b0; inst_rdy = 1'b0;
        repeat (3) step();
        check("rst vld", 32'(inst_vld), 32'd0);
        check("rst wd", 32'(inst_wd), 32'h00);
        check("rst db", 32'(btn_db), 32'd0);
        check("rst cnt", 32'(inst_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Reset mid-pending aborts asynchronously
        sw = 8'h5A; btnS = 1'b1; inst_rdy = 1'b0;
        wait_vld(1'b1, 60, n);
        check("pend vld seen", 32'(n > 0), 32'd1);
        check("pend wd", 32'(inst_wd), 32'h5A);
        #2 rst = 1'b1;
        #1;
        check("abort vld async", 32'(inst_vld), 32'd0);
        check("abort cnt", 32'(inst_cnt), 32'd0);
        check("abort db", 32'(btn_db), 32'd0);
        btnS = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        check("abort no vld", 32'(inst_vld), 32'd0);

        // Clean press: debounce latency window, then vld exactly 2 cycles after btn_db
        sw = 8'h04; inst_rdy = 1'b1; btnS = 1'b1;
        wait_db(1'b1, 40, n);
        check("clean db latency ok", 32'(n >= 15 && n <= 18), 32'd1);
        step();
        check("clean vld +1", 32'(inst_vld), 32'd0);
        step();
        check("clean vld +2", 32'(inst_vld), 32'd1);
        check("clean wd", 32'(inst_wd), 32'h04);
        step();
        check("clean vld pulse end", 32'(inst_vld), 32'd0);
        check("clean cnt", 32'(inst_cnt), 32'd1);
        btnS = 1'b0;
        wait_db(1'b0, 60, n);
        check("clean release", 32'(n > 0), 32'd1);

        // Bounce rejection: 6-cycle runs never span 4 ticks
        sw = 8'h21; bad = 0;
        for (int i = 0; i < 10; i++) begin
            btnS = ~btnS;
            repeat (6) begin
                step();
                if (btn_db !== 1'b0 || inst_vld !== 1'b0) bad++;
            end
        end
        check("bounce quiet", 32'(bad), 32'd0);
        btnS = 1'b1; pulses = 0; prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (inst_vld && !prev) pulses++;
            prev = inst_vld;
        end
        check("bounce one vld", 32'(pulses), 32'd1);
        check("bounce db", 32'(btn_db), 32'd1);
        check("bounce wd", 32'(inst_wd), 32'h21);
        check("bounce cnt", 32'(inst_cnt), 32'd2);
        btnS = 1'b0;
        wait_db(1'b0, 60, n);

        // Backpressure: word held while sw changes, one count on accept
        inst_rdy = 1'b0; sw = 8'h9B; btnS = 1'b1;
        wait_vld(1'b1, 60, n);
        check("bp vld seen", 32'(n > 0), 32'd1);
        sw = 8'hFF; bad = 0;
        repeat (20) begin
            step();
            if (inst_vld !== 1'b1 || inst_wd !== 8'h9B) bad++;
        end
        check("bp hold", 32'(bad), 32'd0);
        check("bp cnt before", 32'(inst_cnt), 32'd2);
        inst_rdy = 1'b1;
        step();
        check("bp vld drop", 32'(inst_vld), 32'd0);
        check("bp cnt after", 32'(inst_cnt), 32'd3);
        check("bp wd kept", 32'(inst_wd), 32'h9B);
        btnS = 1'b0;
        wait_db(1'b0, 60, n);

        // Held button: one instruction only
        sw = 8'h12; btnS = 1'b1; pulses = 0; prev = 1'b0;
        repeat (200) begin
            step();
            if (inst_vld && !prev) pulses++;
            prev = inst_vld;
        end
        check("held one vld", 32'(pulses), 32'd1);
        check("held cnt", 32'(inst_cnt), 32'd4);
        btnS = 1'b0;
        wait_db(1'b0, 60, n);
        press(8'h45, "second");
        check("second cnt", 32'(inst_cnt), 32'd5);

        // Counter wrap
        for (int i = 0; i < 251; i++) press(8'hC0, "wrap");
        check("wrap to zero", 32'(inst_cnt), 32'd0);
        for (int i = 0; i < 5; i++) press(8'hC0, "wrap2");
        check("wrap cnt", 32'(inst_cnt), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_capture.md
Name: inst_capture

Overview:
- Front-end stage of the nexys3 calculator, directly upstream of the instruction decoder/executor.
- Synchronizes the raw slide switches and the btnS push-button, then debounces btnS.
- On each clean press it latches the 8-bit switch word and delivers it as exactly one valid/ready transfer (inst_vld/inst_wd) to the executor.
- Keeps a running count of instructions issued, for LED/debug use.

Parameters:
- SAMPLE_DIV, 10000, clk cycles per debounce sample tick (100 us at 100 MHz).
- STABLE_N, 4, consecutive identical samples required to change the debounced level.
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, asynchronous, active-high.
- sw  input  8  raw switch word (instruction encoding {op[1:0], ra[1:0], rb/immd...}).
- btnS  input  1  raw, bouncy execute button.
- inst_rdy  input  1  executor can accept an instruction this cycle.
- inst_vld  output  1  inst_wd is valid; transfer occurs when inst_vld && inst_rdy.
- inst_wd  output  8  captured instruction word.
- btn_db  output  1  debounced btnS level (debug).
- inst_cnt  output  CNT_W  number of completed transfers, modulo 2^CNT_W.

Behaviour:
- Reset values, all applied asynchronously on rst:
  - inst_vld=0, inst_wd=8'h00, btn_db=0, inst_cnt=0.
  - Sample divider=0, stable counter=0, synchronizers=0, FSM=IDLE.
- Synchronization:
  - sw and btnS each pass through a 2-flop synchronizer (sw_s, btn_s).
  - All downstream logic uses only sw_s and btn_s.
- Sample tick:
  - The divider counts 0..SAMPLE_DIV-1.
  - tick=1 for the single cycle in which the divider equals SAMPLE_DIV-1; the divider then wraps to 0.
- Debounce, evaluated on tick only:
  - If btn_s==btn_db, the stable counter is cleared.
  - Otherwise the stable counter increments.
  - When the counter reaches STABLE_N-1 on a tick with btn_s!=btn_db, btn_db toggles and the counter clears.
  - Any sample equal to btn_db resets the count, so glitches shorter than STABLE_N ticks never reach btn_db.
- Press event:
  - press=1 for one cycle when btn_db rises (registered compare against the previous btn_db).
- FSM:
  - IDLE:
    - On press, inst_wd<=sw_s (sampled in the press cycle), inst_vld<=1, go to PEND.
  - PEND:
    - inst_vld is held high and inst_wd is held stable.
    - On a cycle with inst_rdy=1, the transfer completes: inst_vld<=0 on the next edge, inst_cnt increments (wraps 2^CNT_W-1 -> 0), go to WAIT_REL.
    - inst_rdy already high when PEND is entered gives a one-cycle inst_vld pulse.
  - WAIT_REL:
    - Wait for btn_db==0, then go to IDLE.
    - Presses are ignored until the button is released, so one press yields exactly one instruction.
  - If btn_db falls while in PEND, the pending instruction still completes, then the FSM goes to WAIT_REL and immediately to IDLE.
- Switch changes:
  - sw changes after the capture cycle do not affect inst_wd.
  - sw changes between presses are ignored.
- Latency:
  - Raw btnS rise to inst_vld is 2 sync cycles + STABLE_N ticks + 2 cycles, i.e. about 400 us at the defaults.
- Reset mid-operation:
  - Asserting rst in any state aborts a pending instruction; no transfer occurs and inst_cnt is not incremented.
  - A button held across reset release must be seen fully debounced from btn_db=0. It therefore produces a press after STABLE_N ticks; this is intended.
- Simultaneous events:
  - press is only acted on in IDLE.
  - rst dominates all other inputs.

Decomposition:
- Shared package (calc_pkg):
  - Instruction field constants OP_PUSH=2'b00, OP_ADD=2'b01, OP_MULT=2'b10, OP_SEND=2'b11.
  - Field bit positions.
  - FSM state encoding IDLE/PEND/WAIT_REL.
- One natural sub-module, btn_debounce: synchronizer, divider and stable counter, producing btn_db.
  - It is parameterized by SAMPLE_DIV and STABLE_N.
  - It is reusable for btnR in later labs.
- Capture FSM and counter stay in inst_capture.

Test Plan:
- Clean press: sw=8'h04, btnS high for 3 ms, inst_rdy=1 -> one inst_vld pulse, inst_wd=8'h04, inst_cnt=1, btn_db high about 400 us after the press.
- Bounce rejection: btnS toggling every 50 us for 1 ms, then steady high -> btn_db rises only after the steady period, exactly one inst_vld.
- Backpressure: inst_rdy=0 at press with sw=8'h9B (MULT 1,2,3), then inst_rdy=1 after 20 cycles -> inst_vld held 20+ cycles, inst_wd constant 8'h9B while sw changes to 8'hFF, inst_cnt increments once.
- Held button: btnS held high for 10 ms -> exactly one instruction, then a second press after release -> inst_cnt=2.
- Counter wrap: CNT_W=8, 256 presses with sw=8'hC0 -> inst_cnt returns to 0, every inst_wd=8'hC0.
- Reset mid-pending: rst asserted in PEND with inst_rdy=0 -> inst_vld=0 immediately (async), inst_cnt unchanged, FSM IDLE after release.
